// File: rtl/unslice_pkg.sv
// Shared types and width helpers for the depth-to-space (unslice) stage.
package unslice_pkg;

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_EVEN_A = 3'd1,
    S_EVEN_B = 3'd2,
    S_ODD_A  = 3'd3,
    S_ODD_B  = 3'd4
  } state_t;

  // Full-resolution side length produced from a sub-map side length.
  function automatic int out_width(input int w);
    return 2 * w;
  endfunction

  // Counter width able to index 0..w-1, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/unslice_if.sv
// Beat input and pixel output handshake bundle of the unslice stage.
interface unslice_if #(
  parameter int WIDTH_each_data = 16
);
  logic [WIDTH_each_data-1:0] in_data_1;
  logic [WIDTH_each_data-1:0] in_data_2;
  logic [WIDTH_each_data-1:0] in_data_3;
  logic [WIDTH_each_data-1:0] in_data_4;
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH_each_data-1:0] out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_eol;
  logic                       out_last;
  logic                       busy;

  modport slave (
    input  in_data_1, in_data_2, in_data_3, in_data_4, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_eol, out_last, busy
  );

  modport master (
    output in_data_1, in_data_2, in_data_3, in_data_4, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_eol, out_last, busy
  );
endinterface

// File: rtl/unslice_linebuf.sv
// Odd-row line buffer: one synchronous write port, one asynchronous read port.
module unslice_linebuf
  import unslice_pkg::*;
#(
  parameter  int DEPTH = 80,
  parameter  int WIDTH = 32,
  localparam int AW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/unslice.sv
// Depth-to-space merge: four co-located sub-map pixels per beat become a
// raster-order full-resolution pixel stream with row and frame markers.
module unslice
  import unslice_pkg::*;
#(
  parameter int WIDTH_in_data   = 80,
  parameter int WIDTH_each_data = 16
) (
  input logic      clk,
  input logic      rst,
  unslice_if.slave bus
);
  localparam int              WIDTH_out_data = out_width(WIDTH_in_data);
  localparam int              CW             = cnt_width(WIDTH_in_data);
  localparam logic [CW:0]     COL_LAST       = (CW+1)'(WIDTH_out_data - 1);
  localparam logic [CW-1:0]   ROW_LAST       = CW'(WIDTH_in_data - 1);

  state_t                       state, state_nxt;
  logic [CW-1:0]                n, n_nxt, m, m_nxt;
  logic [WIDTH_each_data-1:0]   hold1, hold2;
  logic [2*WIDTH_each_data-1:0] lb_rdata;
  logic                         load, col_last, row_last;
  logic                         in_ready, out_valid, out_eol, out_last;
  logic [WIDTH_each_data-1:0]   out_data;

  // Output column of a B-phase pixel is 2n+1; the row ends when it hits the last column.
  assign col_last = ({n, 1'b1} == COL_LAST);
  assign row_last = (m == ROW_LAST);

  // Writes land at the column the next beat belongs to, so the address is n_nxt.
  unslice_linebuf #(
    .DEPTH (WIDTH_in_data),
    .WIDTH (2*WIDTH_each_data)
  ) u_linebuf (
    .clk   (clk),
    .we    (load),
    .waddr (n_nxt),
    .wdata ({bus.in_data_3, bus.in_data_4}),
    .raddr (n),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOAD;
      n     <= '0;
      m     <= '0;
      hold1 <= '0;
      hold2 <= '0;
    end else begin
      state <= state_nxt;
      n     <= n_nxt;
      m     <= m_nxt;
      if (load) begin
        hold1 <= bus.in_data_1;
        hold2 <= bus.in_data_2;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    n_nxt     = n;
    m_nxt     = m;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_eol   = 1'b0;
    out_last  = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          load      = 1'b1;
          state_nxt = S_EVEN_A;
        end
      end
      S_EVEN_A: begin
        out_valid = 1'b1;
        out_data  = hold1;
        if (bus.out_ready) state_nxt = S_EVEN_B;
      end
      S_EVEN_B: begin
        out_valid = 1'b1;
        out_data  = hold2;
        out_eol   = col_last;
        // Combinational ready lets the next beat load while this pixel leaves.
        in_ready  = bus.out_ready && !col_last;
        if (bus.out_ready) begin
          if (col_last) begin
            n_nxt     = '0;
            state_nxt = S_ODD_A;
          end else begin
            n_nxt = n + 1'b1;
            if (bus.in_valid) begin
              load      = 1'b1;
              state_nxt = S_EVEN_A;
            end else begin
              state_nxt = S_LOAD;
            end
          end
        end
      end
      S_ODD_A: begin
        out_valid = 1'b1;
        out_data  = lb_rdata[2*WIDTH_each_data-1:WIDTH_each_data];
        if (bus.out_ready) state_nxt = S_ODD_B;
      end
      S_ODD_B: begin
        out_valid = 1'b1;
        out_data  = lb_rdata[WIDTH_each_data-1:0];
        out_eol   = col_last;
        out_last  = col_last && row_last;
        if (bus.out_ready) begin
          if (!col_last) begin
            n_nxt     = n + 1'b1;
            state_nxt = S_ODD_A;
          end else begin
            n_nxt     = '0;
            m_nxt     = row_last ? '0 : m + 1'b1;
            state_nxt = S_LOAD;
          end
        end
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_eol   = out_eol;
  assign bus.out_last  = out_last;
  assign bus.busy      = (m != '0) || (n != '0) || (state != S_LOAD);
endmodule

// File: tb/tb_unslice.sv
// Scoreboard bench: a small instance for directed frame scenarios and a
// full-size instance under random valid/ready, both checked against a mapping model.
module tb_unslice;
  localparam int WA = 2;
  localparam int WB = 80;
  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic          eol;
    logic          last;
    logic          odd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   pops_a = 0;
  int   lastpop_a = 0;
  int   st_a = 0;
  int   eol_b = 0;
  int   last_b = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [DW-1:0] o3a[WA], o4a[WA], o3b[WB], o4b[WB];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unslice_if #(.WIDTH_each_data(DW)) bus_a ();
  unslice_if #(.WIDTH_each_data(DW)) bus_b ();

  unslice #(.WIDTH_in_data(WA), .WIDTH_each_data(DW)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  unslice #(.WIDTH_in_data(WB), .WIDTH_each_data(DW)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] enc(input int k, input int m, input int n);
    return DW'((k << 12) | (m << 8) | (n << 4));
  endfunction

  // Row 2m is pixels 1,2 of each beat in column order; row 2m+1 (pixels 3,4)
  // follows once the whole sub-map row has arrived.
  task automatic model_a(input int m, input int n, input logic [DW-1:0] d1, d2, d3, d4);
    qa.push_back('{d1, 1'b0, 1'b0, 1'b0});
    qa.push_back('{d2, n == WA-1, 1'b0, 1'b0});
    o3a[n] = d3;
    o4a[n] = d4;
    if (n == WA-1)
      for (int j = 0; j < WA; j++) begin
        qa.push_back('{o3a[j], 1'b0, 1'b0, 1'b1});
        qa.push_back('{o4a[j], j == WA-1, (j == WA-1) && (m == WA-1), 1'b1});
      end
  endtask

  task automatic model_b(input int m, input int n, input logic [DW-1:0] d1, d2, d3, d4);
    qb.push_back('{d1, 1'b0, 1'b0, 1'b0});
    qb.push_back('{d2, n == WB-1, 1'b0, 1'b0});
    o3b[n] = d3;
    o4b[n] = d4;
    if (n == WB-1)
      for (int j = 0; j < WB; j++) begin
        qb.push_back('{o3b[j], 1'b0, 1'b0, 1'b1});
        qb.push_back('{o4b[j], j == WB-1, (j == WB-1) && (m == WB-1), 1'b1});
      end
  endtask

  // Directed run on the small instance: optional 2-cycle input gap, 3-cycle
  // output stall, or reset abort once abort_at pixels have left.
  task automatic run_a(input int frames, input int gap_at, input int bp_at, input int abort_at);
    int nb = frames * WA * WA;
    int b = 0;
    int k = 0;
    int p0 = pops_a;
    int bm, bn;
    logic gap, bp;
    while (1) begin
      @(negedge clk);
      if (k == 0) begin
        check("a_idle_busy", 32'(bus_a.busy), 0);
        st_a = cyc;
      end
      if (b == nb && qa.size() == 0) break;
      if (k >= 400) begin
        total++; bad++;
        $display("FAIL a_timeout beats=%0d of %0d pending=%0d", b, nb, qa.size());
        break;
      end
      if (abort_at >= 0 && pops_a - p0 == abort_at) begin
        check("a_pre_abort_pixel", 32'({bus_a.out_valid, bus_a.out_data}), 32'h13000);
        rst_a = 1'b1;
        bus_a.in_valid = 1'b0;
        #1;
        check("a_rst_out_valid", 32'(bus_a.out_valid), 0);
        check("a_rst_busy", 32'(bus_a.busy), 0);
        check("a_rst_in_ready", 32'(bus_a.in_ready), 1);
        check("a_rst_data_marks", 32'({bus_a.out_data, bus_a.out_eol, bus_a.out_last}), 0);
        qa.delete();
        @(posedge clk);
        #2 rst_a = 1'b0;
        return;
      end
      gap = (gap_at >= 0) && (k >= gap_at) && (k < gap_at + 2);
      bp  = (bp_at >= 0) && (k >= bp_at) && (k < bp_at + 3);
      bm = (b / WA) % WA;
      bn = b % WA;
      bus_a.in_valid  = (b < nb) && !gap;
      bus_a.in_data_1 = enc(1, bm, bn);
      bus_a.in_data_2 = enc(2, bm, bn);
      bus_a.in_data_3 = enc(3, bm, bn);
      bus_a.in_data_4 = enc(4, bm, bn);
      bus_a.out_ready = !bp;
      #1;
      if (bp) begin
        check("a_bp_hold_data", 32'({bus_a.out_valid, bus_a.out_data}), 32'h12000);
        check("a_bp_no_accept", 32'(bus_a.in_ready), 0);
      end
      if (gap_at >= 0 && k == gap_at + 2) check("a_gap_bubble", 32'(bus_a.out_valid), 0);
      if (bus_a.in_valid && bus_a.in_ready) begin
        model_a(bm, bn, bus_a.in_data_1, bus_a.in_data_2, bus_a.in_data_3, bus_a.in_data_4);
        b++;
      end
      k++;
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
  endtask

  task automatic run_b();
    int nb = WB * WB;
    int b = 0;
    int k = 0;
    while (1) begin
      @(negedge clk);
      if (b == nb && qb.size() == 0) break;
      if (k >= 95000) begin
        total++; bad++;
        $display("FAIL b_timeout beats=%0d of %0d pending=%0d", b, nb, qb.size());
        break;
      end
      bus_b.in_valid  = (b < nb) && ($urandom_range(1) == 1);
      bus_b.in_data_1 = DW'($urandom);
      bus_b.in_data_2 = DW'($urandom);
      bus_b.in_data_3 = DW'($urandom);
      bus_b.in_data_4 = DW'($urandom);
      bus_b.out_ready = ($urandom_range(1) == 1);
      #1;
      if (bus_b.in_valid && bus_b.in_ready) begin
        model_b(b / WB, b % WB, bus_b.in_data_1, bus_b.in_data_2, bus_b.in_data_3, bus_b.in_data_4);
        b++;
      end
      k++;
    end
    bus_b.in_valid  = 1'b0;
    bus_b.out_ready = 1'b1;
  endtask

  initial begin : mon_a
    logic stall;
    logic [DW-1:0] sd;
    logic se, sl;
    exp_t e;
    stall = 1'b0;
    sd = '0; se = 1'b0; sl = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_a) begin
        stall = 1'b0;
        continue;
      end
      if (stall)
        check("a_stall_stable", 32'({bus_a.out_valid, bus_a.out_eol, bus_a.out_last, bus_a.out_data}),
              32'({1'b1, se, sl, sd}));
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (qa.size() == 0) check("a_unexpected_pixel", 32'(bus_a.out_data), 32'hffff_ffff);
        else begin
          e = qa.pop_front();
          check("a_pixel", 32'({bus_a.out_data, bus_a.out_eol, bus_a.out_last}),
                32'({e.data, e.eol, e.last}));
          if (e.odd) check("a_odd_in_ready", 32'(bus_a.in_ready), 0);
          pops_a++;
          lastpop_a = cyc;
        end
      end
      stall = bus_a.out_valid && !bus_a.out_ready;
      sd = bus_a.out_data;
      se = bus_a.out_eol;
      sl = bus_a.out_last;
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_b) continue;
      if (bus_b.out_valid && bus_b.out_ready) begin
        if (bus_b.out_eol) eol_b++;
        if (bus_b.out_last) last_b++;
        if (qb.size() == 0) check("b_unexpected_pixel", 32'(bus_b.out_data), 32'hffff_ffff);
        else begin
          e = qb.pop_front();
          check("b_pixel", 32'({bus_b.out_data, bus_b.out_eol, bus_b.out_last}),
                32'({e.data, e.eol, e.last}));
        end
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    bus_a.in_data_1 = '0; bus_a.in_data_2 = '0; bus_a.in_data_3 = '0; bus_a.in_data_4 = '0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
    bus_b.in_data_1 = '0; bus_b.in_data_2 = '0; bus_b.in_data_3 = '0; bus_b.in_data_4 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("a_reset_ctrl", 32'({bus_a.out_valid, bus_a.out_eol, bus_a.out_last, bus_a.busy, bus_a.in_ready}), 32'b00001);
    check("a_reset_data", 32'(bus_a.out_data), 0);
    check("b_reset_ctrl", 32'({bus_b.out_valid, bus_b.out_eol, bus_b.out_last, bus_b.busy, bus_b.in_ready}), 32'b00001);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    fork
      begin
        run_a(1, -1, -1, -1);
        check("a_frame_cycles", 32'(lastpop_a - st_a), 17);
        run_a(1, -1, 2, -1);
        run_a(1, 1, -1, -1);
        run_a(1, -1, -1, 4);
        run_a(1, -1, -1, -1);
        check("a_restart_frame_cycles", 32'(lastpop_a - st_a), 17);
        run_a(2, -1, -1, -1);
        check("a_two_frame_cycles", 32'(lastpop_a - st_a), 35);
      end
      run_b();
    join
    check("a_queue_drained", 32'(qa.size()), 0);
    check("b_queue_drained", 32'(qb.size()), 0);
    check("b_eol_count", 32'(eol_b), 2 * WB);
    check("b_last_count", 32'(last_b), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
